// File: rtl/shared_output_arbiter.sv
// shared_output_arbiter
// Round-robin owner selection for one shared output net. At most one requester
// owns the net at a time. An owner can hold it for at most MAX_HOLD consecutive
// cycles while others wait. When the owner drops its request, the next owner
// takes over at the same edge, with no idle cycle in between.
// Optional feature macro: SHARED_OUTPUT_ARBITER_LOCK_EN adds a per-requester
// `lock` input. While the owner's lock bit is set, the hold limit is suspended.
module shared_output_arbiter #(
  parameter int N_REQ    = 15,
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     data,
`ifdef SHARED_OUTPUT_ARBITER_LOCK_EN
  input  logic [N_REQ-1:0]           lock,
`endif
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   gnt_id,
  output logic                       busy,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data
);

  localparam int ID_W = $clog2(N_REQ);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [7:0]        hold_q, hold_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;

  logic [ID_W-1:0]   owner_inc;
  logic [ID_W-1:0]   search_start;
  logic              exclude_owner;
  logic              sel_found;
  logic [ID_W-1:0]   sel_idx;
  logic              owner_locked;

  // The requester after the current owner, wrapping from N_REQ-1 to 0.
  assign owner_inc = (owner_q == LAST_ID) ? '0 : owner_q + ID_W'(1);

  // While an owner is active, the search starts just after it. This keeps the
  // rotation fair even when the owner was picked from IDLE with an old pointer.
  assign search_start  = (state_q == GRANT) ? owner_inc : ptr_q;
  assign exclude_owner = (state_q == GRANT);

`ifdef SHARED_OUTPUT_ARBITER_LOCK_EN
  assign owner_locked = lock[owner_q];
`else
  assign owner_locked = 1'b0;
`endif

  // Circular search for the first pending requester, skipping the current owner.
  always_comb begin
    int idx;
    // NOTE: every signal written in a combinational block gets a default first; a path that leaves one unassigned infers a latch.
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(search_start) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!sel_found && req[idx] && !(exclude_owner && (idx == int'(owner_q)))) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(idx);
      end
    end
  end

  // State register: FSM state, owner, hold counter, round-robin pointer, grant vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      hold_q  <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state logic: grant from idle, release or hand over, hold-limit rotation.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = GRANT;
          owner_d = sel_idx;
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          ptr_d = owner_inc;
          if (sel_found) begin
            owner_d = sel_idx;
            hold_d  = 8'd1;
          end else begin
            state_d = IDLE;
            owner_d = '0;
            hold_d  = '0;
          end
        end else if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + 8'd1;
        end else if (!owner_locked && sel_found) begin
          ptr_d   = owner_inc;
          owner_d = sel_idx;
          hold_d  = 8'd1;
        end
        // Otherwise the owner keeps the net and hold_q stays saturated.
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Output logic: one-hot grant decode of the next owner, and the combinational output mux.
  always_comb begin
    gnt_d = '0;
    if (state_d == GRANT) gnt_d[owner_d] = 1'b1;
    out_valid = (state_q == GRANT) && req[owner_q];
    out_data  = '0;
    if (out_valid) out_data = data[int'(owner_q)*WIDTH +: WIDTH];
  end

  assign gnt    = gnt_q;
  assign gnt_id = owner_q;
  assign busy   = (state_q == GRANT);

endmodule

// File: tb/tb_shared_output_arbiter.sv
// tb_shared_output_arbiter
// The stimulus side drives req/data at the falling edge. It steps a reference
// model of the arbitration rules and queues the expected grant state. The
// monitor pops one expectation after each rising edge and compares it.
module tb_shared_output_arbiter;

  localparam int N    = 15;
  localparam int W    = 1;
  localparam int MAXH = 4;
  localparam int IDW  = $clog2(N);
  localparam int DW   = N * W;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [DW-1:0]  data;
`ifdef SHARED_OUTPUT_ARBITER_LOCK_EN
  logic [N-1:0]   lock = '0;
`endif
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           out_valid;
  logic [W-1:0]   out_data;

  shared_output_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MAXH)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .data(data),
`ifdef SHARED_OUTPUT_ARBITER_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt),
    .gnt_id(gnt_id),
    .busy(busy),
    .out_valid(out_valid),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   g;
    logic [IDW-1:0] id;
    logic           b;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: the owner (-1 when idle), the number of consecutive
  // cycles it has held the net, and the requester where the next search starts.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start, input int skip);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j] && j != skip) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r);
    int j;
    logic lk;
    lk = 1'b0;
    if (m_owner < 0) begin
      j = pick(r, m_ptr, -1);
      if (j >= 0) begin
        m_owner = j;
        m_held  = 1;
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      j       = pick(r, m_ptr, m_owner);
      m_owner = j;
      m_held  = (j >= 0) ? 1 : 0;
    end else if (m_held < MAXH) begin
      m_held++;
    end else begin
`ifdef SHARED_OUTPUT_ARBITER_LOCK_EN
      lk = lock[m_owner];
`endif
      if (!lk) begin
        j = pick(r, (m_owner + 1) % N, m_owner);
        if (j >= 0) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = j;
          m_held  = 1;
        end
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.g  = '0;
    e.id = '0;
    e.b  = 1'b0;
    if (m_owner >= 0) begin
      e.g[m_owner] = 1'b1;
      e.id = IDW'(m_owner);
      e.b  = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  // Drive new inputs (the caller is at a falling edge), then model the next rising edge.
  task automatic drive(input logic [N-1:0] r, input logic [DW-1:0] d);
    req  = r;
    data = d;
    model_step(r);
    push_expected();
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [DW-1:0] d);
    @(negedge clk);
    drive(r, d);
  endtask

  // Monitor: after each rising edge, compare the DUT with the next queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        logic ov;
        logic [W-1:0] od;
        e  = exp_q.pop_front();
        ov = e.b && req[e.id];
        od = ov ? data[int'(e.id)*W +: W] : '0;
        check("gnt", 32'(gnt), 32'(e.g));
        check("gnt_id", 32'(gnt_id), 32'(e.id));
        check("busy", 32'(busy), 32'(e.b));
        check("out_valid", 32'(out_valid), 32'(ov));
        check("out_data", 32'(out_data), 32'(od));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    rst  = 1'b1;
    req  = '1;
    data = '1;

    // Reset holds everything idle, even with every requester asserting.
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    // Release reset. Requester 0 is granted at the first edge.
    @(negedge clk);
    rst = 1'b0;
    drive('1, '1);
    @(posedge clk); #2;
    check("release_gnt", 32'(gnt), 32'h0001);

    // A single requester holds the net. Its counter saturates and it never rotates.
    for (int i = 0; i < 10; i++) cycle(15'h0004, 15'h0004);
    @(posedge clk); #2;
    check("single_gnt", 32'(gnt), 32'h0004);
    check("single_out_data", 32'(out_data), 32'd1);

    // Fairness: with every requester asserting, each owner holds the net for MAX_HOLD cycles in turn.
    for (int i = 0; i < 2 * N * MAXH + 4; i++) cycle('1, DW'($urandom));

    // Zero-bubble handover from owner 3 to owner 7.
    cycle('0, '0);
    cycle('0, '0);
    cycle(15'h0008, 15'h0008);
    cycle(15'h0088, 15'h0088);
    @(posedge clk); #2;
    check("pre_handover_gnt", 32'(gnt), 32'h0008);
    cycle(15'h0080, 15'h0080);
    @(posedge clk); #2;
    check("handover_gnt", 32'(gnt), 32'h0080);
    check("handover_busy", 32'(busy), 32'd1);

    // Asynchronous reset between edges while owner 5 holds the net.
    cycle('0, '0);
    cycle('0, '0);
    cycle(15'h0020, '1);
    cycle(15'h0020, '1);
    @(posedge clk); #3;
    check("pre_reset_gnt", 32'(gnt), 32'h0020);
    rst = 1'b1;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(15'h1030, '1);
    @(posedge clk); #2;
    check("post_reset_lowest", 32'(gnt), 32'h0010);

`ifdef SHARED_OUTPUT_ARBITER_LOCK_EN
    // A locked owner keeps the net past the hold limit. Clearing the lock rotates at the next edge.
    cycle('0, '0);
    cycle('0, '0);
    lock = 15'h0020;
    for (int i = 0; i < 20; i++) cycle(15'h0060, '1);
    @(posedge clk); #2;
    check("lock_hold_gnt", 32'(gnt), 32'h0020);
    @(negedge clk);
    lock = '0;
    drive(15'h0060, '1);
    @(posedge clk); #2;
    check("lock_release_gnt", 32'(gnt), 32'h0040);
`endif

    // Random phase. Each request bit flips rarely, so holds, drops and rotations all occur.
    r = '0;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
`ifdef SHARED_OUTPUT_ARBITER_LOCK_EN
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) lock = N'($urandom);
      drive(r, DW'($urandom));
`else
      cycle(r, DW'($urandom));
`endif
    end

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_output_arbiter.md
# shared_output_arbiter

Round-robin arbiter that shares one output net between up to N_REQ submodule instances, so that no two instances ever drive the shared signal in the same cycle. It sits in `top` between the replicated submodule instances and the shared output port. Each instance requests ownership and presents its data. The arbiter grants one owner at a time, bounds how long an owner may hold the grant, and muxes the owner's data onto the shared output.

## Interface
Parameters:
- N_REQ, 15, number of requesters (2..32)
- WIDTH, 1, width of each requester's data and of the shared output
- MAX_HOLD, 4, maximum consecutive grant cycles per owner while others wait (1..255)

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- req  input  N_REQ  per-requester ownership request, level
- data  input  N_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- gnt  output  N_REQ  one-hot grant, registered
- gnt_id  output  $clog2(N_REQ)  index of current owner, registered; 0 when idle
- busy  output  1  registered; 1 while in GRANT state
- out_valid  output  1  combinational: busy && req[gnt_id]
- out_data  output  WIDTH  combinational: data of owner when out_valid, else 0

## Operation
- State registers: state (IDLE/GRANT), owner index, hold_cnt (8 bit), rr_ptr (owner search start).
- Reset values: state=IDLE, gnt=0, gnt_id=0, busy=0, rr_ptr=0, hold_cnt=0. Consequently out_valid=0 and out_data=0.
- Selection: lowest index j found by searching rr_ptr, rr_ptr+1, … modulo N_REQ, with req[j]=1 and j≠current owner where applicable.
- IDLE: if any req=1, go to GRANT with owner=selected, hold_cnt=1. Otherwise stay idle.
- GRANT, owner dropped req: release at this edge. Set rr_ptr=owner+1 mod N_REQ. If another request exists, grant it at the same edge (no idle bubble) with hold_cnt=1. Otherwise go to IDLE.
- GRANT, owner holds req, hold_cnt<MAX_HOLD: stay, hold_cnt+1.
- GRANT, owner holds req, hold_cnt==MAX_HOLD, another req pending: rotate to selected with rr_ptr=owner+1, hold_cnt=1.
- GRANT, owner holds req, hold_cnt==MAX_HOLD, no other req: stay, hold_cnt saturates at MAX_HOLD.
- gnt is always one-hot or zero. It is never multi-hot, including across reset.

## Timing
- req rising at edge t gives gnt/busy at t+1 (1-cycle grant latency) when IDLE.
- Handover is zero-bubble: owner drops req before edge t, and the new gnt is valid after edge t.
- out_data follows data combinationally while owned. There is no added latency.
- Worst-case wait for any requester: (N_REQ-1)*MAX_HOLD cycles after it asserts req, lock disabled.
- rst asserted mid-grant forces all outputs to reset values immediately (asynchronous). The first grant after deassertion is at the edge following the first sampled req.
- Requests from indices ≥N_REQ do not exist. rr_ptr wrap N_REQ-1 → 0.

## Configuration
- SHARED_OUTPUT_ARBITER_LOCK_EN
  - Defined: adds input `lock` (N_REQ bits). While lock[owner]=1 and req[owner]=1, the hold limit is ignored and hold_cnt saturates. Clearing lock with hold_cnt==MAX_HOLD and another request pending rotates at the next edge.
  - Undefined: no `lock` port, and MAX_HOLD always applies.

## Test plan
- Reset: rst=1 with req=all ones -> gnt=0, busy=0, out_valid=0, out_data=0. Release rst -> gnt=0x0001, gnt_id=0 one cycle later.
- Single requester: req=0x0004 for 10 cycles, data[2]=1 -> gnt=0x0004 from cycle 1, out_data=1 throughout, no rotation, hold_cnt saturates at 4.
- Fairness: N_REQ=15, MAX_HOLD=4, req=all ones constantly -> owner sequence 0,1,…,14,0, each held exactly 4 cycles, never two gnt bits set.
- Zero-bubble handover: owner 3 drops req while req[7]=1 -> gnt changes 0x0008→0x0080 at the same edge, busy stays 1.
- Async reset mid-grant: assert rst between edges while gnt=0x0020 -> gnt=0 immediately. After release, rr_ptr=0, so the first grant goes to the lowest requesting index.
- Lock (macro defined): lock[5]=1, req[5]=1, req[6]=1 for 20 cycles -> owner stays 5. Drop lock -> gnt=0x0040 at the next edge.
